// File: rtl/vga_vidout.sv
// ============================================================================
// Module  : vga_vidout
// Brief   : 640x480@60 VGA timing, VRAM fetch/snoop bus arbitration and a
//           centred monochrome frame-buffer serialiser.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_vidout #(
  parameter int H_OFFSET  = 64,
  parameter int V_OFFSET  = 69,
  parameter int SE_WIDTH  = 512,
  parameter int SE_HEIGHT = 342
) (
  input  logic        pixClock,
  input  logic        nReset,
  input  logic        vidBufSel,
  input  logic [14:0] snpAddr,
  input  logic [7:0]  snpData,
  input  logic        nsnpWE,
  input  logic        nsnpCE0,
  input  logic        nsnpCE1,
  input  logic [7:0]  vramDataIn,
  output logic [2:0]  seq,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        vramDataOE,
  output logic        nvramWE,
  output logic        nvramOE,
  output logic        nvramCE0,
  output logic        nvramCE1,
  output logic        vidOut,
  output logic        nhSync,
  output logic        nvSync
);

  localparam logic [9:0] c_H_LAST     = 10'd799;
  localparam logic [9:0] c_V_LAST     = 10'd524;
  localparam logic [9:0] c_HS_FIRST   = 10'd656;
  localparam logic [9:0] c_HS_LAST    = 10'd751;
  localparam logic [9:0] c_VS_FIRST   = 10'd490;
  localparam logic [9:0] c_VS_LAST    = 10'd491;
  localparam logic [9:0] c_HA_FIRST   = 10'(H_OFFSET);
  localparam logic [9:0] c_HA_LAST    = 10'(H_OFFSET + SE_WIDTH - 1);
  localparam logic [9:0] c_VA_FIRST   = 10'(V_OFFSET);
  localparam logic [9:0] c_VA_LAST    = 10'(V_OFFSET + SE_HEIGHT - 1);
  localparam logic [9:0] c_FE_FIRST   = 10'(H_OFFSET - 8);
  localparam logic [9:0] c_FE_LAST    = 10'(H_OFFSET + SE_WIDTH - 16);
  localparam logic [9:0] c_FA_RSTLINE = 10'(V_OFFSET - 1);

  logic [9:0]  r_hCount;
  logic [9:0]  r_vCount;
  logic [14:0] r_fetchAddr;
  logic [7:0]  r_hold;
  logic [7:0]  r_shift;
  logic        r_bufSel;
  logic        r_vidOut;
  logic        r_nhSync;
  logic        r_nvSync;

  logic [9:0]  w_hNext;
  logic        w_hActive;
  logic        w_vActive;
  logic        w_fetch;
  logic        w_loadShift;

  assign w_hNext   = (r_hCount == c_H_LAST) ? 10'd0 : r_hCount + 10'd1;
  assign w_hActive = (r_hCount >= c_HA_FIRST) && (r_hCount <= c_HA_LAST);
  assign w_vActive = (r_vCount >= c_VA_FIRST) && (r_vCount <= c_VA_LAST);

  // One byte is fetched a full cell ahead of the pixels it feeds.
  assign w_fetch = nReset && w_vActive && (r_hCount[2:0] == 3'd0) &&
                   (r_hCount >= c_FE_FIRST) && (r_hCount <= c_FE_LAST);

  assign w_loadShift = (w_hNext[2:0] == 3'd0) &&
                       (w_hNext >= c_HA_FIRST) && (w_hNext <= c_HA_LAST);

  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_hCount    <= 10'd0;
      r_vCount    <= 10'd0;
      r_fetchAddr <= 15'd0;
      r_hold      <= 8'd0;
      r_shift     <= 8'd0;
      r_bufSel    <= 1'b1;
      r_vidOut    <= 1'b0;
      r_nhSync    <= 1'b1;
      r_nvSync    <= 1'b1;
    end else begin
      r_hCount <= w_hNext;
      if (r_hCount == c_H_LAST) begin
        r_vCount <= (r_vCount == c_V_LAST) ? 10'd0 : r_vCount + 10'd1;
      end

      // Buffer choice is latched once per line so a mid-line flip cannot tear.
      if (r_hCount == 10'd0) begin
        r_bufSel <= vidBufSel;
      end

      if ((r_hCount == c_H_LAST) && (r_vCount == c_FA_RSTLINE)) begin
        r_fetchAddr <= 15'd0;
      end else if (w_fetch) begin
        r_fetchAddr <= r_fetchAddr + 15'd1;
        r_hold      <= vramDataIn;
      end

      if (w_loadShift) begin
        r_shift <= r_hold;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end

      // Mac frame buffer stores 1 = black.
      r_vidOut <= (w_hActive && w_vActive) ? ~r_shift[7] : 1'b0;
      r_nhSync <= ~((r_hCount >= c_HS_FIRST) && (r_hCount <= c_HS_LAST));
      r_nvSync <= ~((r_vCount >= c_VS_FIRST) && (r_vCount <= c_VS_LAST));
    end
  end

  always_comb begin
    vramAddr    = snpAddr;
    vramDataOut = snpData;
    vramDataOE  = ~nsnpWE;
    nvramWE     = nsnpWE;
    nvramOE     = 1'b1;
    nvramCE0    = nsnpCE0;
    nvramCE1    = nsnpCE1;
    if (w_fetch) begin
      vramAddr   = r_fetchAddr;
      vramDataOE = 1'b0;
      nvramWE    = 1'b1;
      nvramOE    = 1'b0;
      nvramCE1   = ~r_bufSel;
      nvramCE0   = r_bufSel;
    end
  end

  assign seq    = r_hCount[2:0];
  assign vidOut = r_vidOut;
  assign nhSync = r_nhSync;
  assign nvSync = r_nvSync;

endmodule

`default_nettype wire

// File: tb/tb_vga_vidout.sv
// ============================================================================
// Module  : tb_vga_vidout
// Brief   : Scoreboard bench for vga_vidout (fetch queue plus pixel/sync model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_vidout;

  localparam int VOFF = 4;
  localparam int VHGT = 8;

  logic        pixClock = 1'b0;
  logic        nReset;
  logic        vidBufSel;
  logic [14:0] snpAddr;
  logic [7:0]  snpData;
  logic        nsnpWE;
  logic        nsnpCE0;
  logic        nsnpCE1;
  logic [7:0]  vramDataIn;
  logic [2:0]  seq;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        vramDataOE;
  logic        nvramWE;
  logic        nvramOE;
  logic        nvramCE0;
  logic        nvramCE1;
  logic        vidOut;
  logic        nhSync;
  logic        nvSync;

  always #10 pixClock = ~pixClock;

  vga_vidout #(
    .H_OFFSET (64),
    .V_OFFSET (VOFF),
    .SE_WIDTH (512),
    .SE_HEIGHT(VHGT)
  ) dut (
    .pixClock   (pixClock),
    .nReset     (nReset),
    .vidBufSel  (vidBufSel),
    .snpAddr    (snpAddr),
    .snpData    (snpData),
    .nsnpWE     (nsnpWE),
    .nsnpCE0    (nsnpCE0),
    .nsnpCE1    (nsnpCE1),
    .vramDataIn (vramDataIn),
    .seq        (seq),
    .vramAddr   (vramAddr),
    .vramDataOut(vramDataOut),
    .vramDataOE (vramDataOE),
    .nvramWE    (nvramWE),
    .nvramOE    (nvramOE),
    .nvramCE0   (nvramCE0),
    .nvramCE1   (nvramCE1),
    .vidOut     (vidOut),
    .nhSync     (nhSync),
    .nvSync     (nvSync)
  );

  function automatic logic [7:0] memByte(input int n);
    logic [31:0] t;
    t = n;
    return (n == 0) ? 8'h80 : t[7:0];
  endfunction

  assign vramDataIn = memByte(int'(vramAddr));

  typedef struct {
    int          vc;
    int          hc;
    logic [14:0] addr;
    bit          mainSel;
  } fetch_t;

  fetch_t q[$];
  int     nCompared   = 0;
  int     nMismatched = 0;
  int     bh = 0;
  int     bv = 0;
  bit     monOn = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d (line %0d, col %0d)", name, act, exp, bv, bh);
    end
  endtask

  task automatic pushLine(input int v, input int lastCell, input bit mainSel);
    fetch_t e;
    for (int c = 0; c <= lastCell; c++) begin
      e.vc      = v;
      e.hc      = 56 + 8 * c;
      e.addr    = 15'((v - VOFF) * 64 + c);
      e.mainSel = mainSel;
      q.push_back(e);
    end
  endtask

  task automatic waitAt(input int v, input int h);
    int n;
    n = 0;
    do begin
      @(posedge pixClock);
      n++;
    end while (!(bv == v && bh == h) && n < 30000);
    if (!(bv == v && bh == h)) begin
      nCompared++;
      nMismatched++;
      $display("FAIL waitAt: reached %0d,%0d required %0d,%0d", bv, bh, v, h);
    end
  endtask

  // Independent reference of the beam position, same edge and reset as the DUT.
  always @(negedge pixClock or negedge nReset) begin
    if (!nReset) begin
      bh = 0;
      bv = 0;
    end else if (bh == 799) begin
      bh = 0;
      bv = (bv == 524) ? 0 : bv + 1;
    end else begin
      bh = bh + 1;
    end
  end

  int          mPh, mPv, mCell, mIdx, mVid, mNh, mNv;
  logic [7:0]  mByte;
  fetch_t      mExp;

  always @(posedge pixClock) begin
    if (monOn) begin
      mPh = (bh == 0) ? 799 : bh - 1;
      mPv = (bh == 0) ? ((bv == 0) ? 524 : bv - 1) : bv;
      mVid = 0;
      if (mPh >= 64 && mPh <= 575 && mPv >= VOFF && mPv <= VOFF + VHGT - 1) begin
        mCell = (mPh - 64) / 8;
        mIdx  = (mPh - 64) % 8;
        mByte = memByte((mPv - VOFF) * 64 + mCell);
        mVid  = mByte[7 - mIdx] ? 0 : 1;
      end
      mNh = (mPh >= 656 && mPh <= 751) ? 0 : 1;
      mNv = (mPv >= 490 && mPv <= 491) ? 0 : 1;
      chk("vidOut", vidOut, mVid);
      chk("nhSync", nhSync, mNh);
      chk("nvSync", nvSync, mNv);
      chk("seq", seq, bh % 8);

      if (!nvramOE) begin
        if (q.size() == 0) begin
          chk("fetch_unexpected", int'(vramAddr), -1);
        end else begin
          mExp = q.pop_front();
          chk("fetch_pos", bv * 1000 + bh, mExp.vc * 1000 + mExp.hc);
          chk("fetch_addr", int'(vramAddr), int'(mExp.addr));
          chk("fetch_ce", int'({nvramCE1, nvramCE0}), mExp.mainSel ? 1 : 2);
          chk("fetch_ctl", int'({nvramWE, vramDataOE}), 2);
        end
      end
    end
  end

  initial begin
    nReset    = 1'b0;
    vidBufSel = 1'b1;
    snpAddr   = 15'h1234;
    snpData   = 8'hC3;
    nsnpWE    = 1'b1;
    nsnpCE0   = 1'b1;
    nsnpCE1   = 1'b1;
    repeat (2) @(posedge pixClock);
    #2;
    chk("rst_vidOut", vidOut, 0);
    chk("rst_nhSync", nhSync, 1);
    chk("rst_nvSync", nvSync, 1);
    chk("rst_seq", seq, 0);
    chk("rst_nvramOE", nvramOE, 1);
    chk("rst_addr_pass", int'(vramAddr), 'h1234);
    chk("rst_data_pass", int'(vramDataOut), 'hC3);
    chk("rst_dataOE", vramDataOE, 0);
    chk("rst_ce1_pass", nvramCE1, 1);

    // Frame 0: main buffer through line 6, alt from line 7, reset mid line 9.
    for (int v = VOFF; v <= 8; v++) pushLine(v, 63, v <= 6);
    pushLine(9, 43, 1'b0);
    monOn  = 1'b1;
    nReset = 1'b1;

    waitAt(5, 3);
    #2;
    nsnpWE  = 1'b0;
    nsnpCE1 = 1'b0;
    snpAddr = 15'h0123;
    snpData = 8'h5A;
    #1;
    chk("snp_addr", int'(vramAddr), 'h0123);
    chk("snp_data", int'(vramDataOut), 'h5A);
    chk("snp_dataOE", vramDataOE, 1);
    chk("snp_nvramOE", nvramOE, 1);
    chk("snp_nvramWE", nvramWE, 0);
    chk("snp_ce", int'({nvramCE1, nvramCE0}), 1);
    @(posedge pixClock);
    #2;
    nsnpWE  = 1'b1;
    nsnpCE1 = 1'b1;
    snpAddr = 15'h1234;
    snpData = 8'hC3;

    waitAt(6, 300);
    #2;
    vidBufSel = 1'b0;

    waitAt(9, 400);
    #2;
    nReset    = 1'b0;
    vidBufSel = 1'b1;
    #1;
    chk("midrst_vidOut", vidOut, 0);
    chk("midrst_nhSync", nhSync, 1);
    chk("midrst_nvSync", nvSync, 1);
    chk("midrst_seq", seq, 0);
    chk("midrst_nvramOE", nvramOE, 1);
    chk("midrst_addr_pass", int'(vramAddr), 'h1234);
    chk("frame0_fetches_left", q.size(), 0);

    // Frame 1 restarts from (0,0): every active line from the main buffer.
    for (int v = VOFF; v <= VOFF + VHGT - 1; v++) pushLine(v, 63, 1'b1);
    repeat (3) @(posedge pixClock);
    #2;
    nReset = 1'b1;

    waitAt(VOFF + VHGT + 1, 10);
    chk("frame1_fetches_left", q.size(), 0);
    monOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire
